// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and stream framing constants for the program loader
package prog_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_WORD,
      S_WRITE,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam int HDR_BYTES      = 2;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/prog_loader_packer.sv
// rtl/prog_loader_packer.sv - little-endian byte-to-word shift register with byte counter
module prog_loader_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   input  logic        clr,
   output logic [31:0] word_out,
   output logic        full
);

   logic [1:0]  idx;
   logic [31:0] word_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx    <= '0;
         word_q <= '0;
      end else if (clr) begin
         idx    <= '0;
         word_q <= '0;
      end else if (shift_en) begin
         word_q[{idx, 3'b000} +: 8] <= byte_in;
         idx                        <= idx + 2'd1;
      end
   end

   // word_out already carries the byte being shifted, so the top can latch it on the last transfer
   always_comb begin
      word_out                     = word_q;
      word_out[{idx, 3'b000} +: 8] = byte_in;
   end

   assign full = (idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams a length-prefixed program image into instruction memory, then releases the PC
// Optional trailing checksum byte: PROG_LOADER_CHECKSUM_EN
import prog_loader_pkg::*;

module prog_loader #(
   parameter int ADDR_W    = 9,
   parameter int MAX_WORDS = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              we0,
   output logic [ADDR_W-1:0] wr_addr0,
   output logic [31:0]       wr_din0,
   output logic              resetpc,
   output logic              busy,
   output logic              error
);

   localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

   state_t      state;
   logic [15:0] n_words;
   logic [15:0] word_idx;
   logic        xfer;
   logic        pk_shift;
   logic        pk_clr;
   logic        pk_full;
   logic [31:0] pk_word;

   assign xfer     = in_valid && in_ready;
   assign pk_shift = xfer && (state == S_WORD);
   assign pk_clr   = xfer && (state == S_HDR1);

   prog_loader_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .shift_en (pk_shift),
      .byte_in  (in_data),
      .clr      (pk_clr),
      .word_out (pk_word),
      .full     (pk_full)
   );

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         csum <= '0;
      end else if (state == S_HDR1) begin
         csum <= '0;
      end else if (pk_shift) begin
         csum <= csum + in_data;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         we0      <= 1'b0;
         wr_addr0 <= '0;
         wr_din0  <= '0;
         resetpc  <= 1'b0;
         busy     <= 1'b0;
         error    <= 1'b0;
         in_ready <= 1'b0;
         n_words  <= '0;
         word_idx <= '0;
      end else begin
         we0 <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (state == S_DONE) resetpc <= 1'b1;
               if (start) begin
                  state    <= S_HDR0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  error    <= 1'b0;
                  resetpc  <= 1'b0;
               end
            end
            S_HDR0: begin
               if (xfer) begin
                  n_words[7:0] <= in_data;
                  state        <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (xfer) begin
                  n_words[15:8] <= in_data;
                  word_idx      <= '0;
                  if ({in_data, n_words[7:0]} == 16'd0) begin
                     state    <= S_DONE;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                  end else if ({in_data, n_words[7:0]} > MAX_N) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     error    <= 1'b1;
                  end else begin
                     state <= S_WORD;
                  end
               end
            end
            S_WORD: begin
               if (xfer && pk_full) begin
                  state    <= S_WRITE;
                  in_ready <= 1'b0;
                  we0      <= 1'b1;
                  wr_addr0 <= {word_idx[ADDR_W-3:0], 2'b00};
                  wr_din0  <= pk_word;
               end
            end
            S_WRITE: begin
               word_idx <= word_idx + 16'd1;
               in_ready <= 1'b1;
               if (word_idx + 16'd1 == n_words) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                  state <= S_CSUM;
`else
                  state    <= S_DONE;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
`endif
               end else begin
                  state <= S_WORD;
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_data == csum) begin
                     state <= S_DONE;
                  end else begin
                     state <= S_ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench: image table, randomized data/backpressure, corner sequences
module tb_prog_loader;

   localparam int ADDR_W    = 9;
   localparam int MAX_WORDS = 128;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   wire               in_ready;
   wire               we0;
   wire  [ADDR_W-1:0] wr_addr0;
   wire  [31:0]       wr_din0;
   wire               resetpc;
   wire               busy;
   wire               error;

   always #5 clk = ~clk;

   prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .we0      (we0),
      .wr_addr0 (wr_addr0),
      .wr_din0  (wr_din0),
      .resetpc  (resetpc),
      .busy     (busy),
      .error    (error)
   );

   int checks = 0;
   int errors = 0;

   logic [ADDR_W-1:0] log_addr[$];
   logic [31:0]       log_data[$];
   logic [31:0]       exp_words[$];
   logic [7:0]        stream[$];

   typedef struct {
      int n;
      int pct;
      bit exp_err;
      bit exp_pc;
      int exp_writes;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // write-port monitor: records every write and checks the handshake is closed during it
   always @(negedge clk) begin
      if (reset === 1'b1 && we0 === 1'b1) begin
         log_addr.push_back(wr_addr0);
         log_data.push_back(wr_din0);
         check("in_ready_low_in_write", 64'(in_ready), 64'd0);
      end
   end

   // reference image: header, then N random little-endian words, optional sum byte
   task automatic build_image(input int n);
      logic [15:0] n16;
      logic [31:0] w;
      logic [7:0]  sum;
      n16 = 16'(n);
      sum = 8'd0;
      exp_words.delete();
      stream.delete();
      stream.push_back(n16[7:0]);
      stream.push_back(n16[15:8]);
      if (n >= 1 && n <= MAX_WORDS) begin
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_words.push_back(w);
            for (int b = 0; b < 4; b++) begin
               stream.push_back(w[8*b +: 8]);
               sum = sum + w[8*b +: 8];
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         stream.push_back(sum);
`endif
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // drives the stream; checks we0 shows up exactly one cycle after each word's 4th byte
   task automatic send(input int pct, input int nw);
      int p      = 0;
      int budget = 0;
      bit fourth = 1'b0;
      bit v;
      while (p < stream.size()) begin
         @(negedge clk);
         check("we0_latency", 64'(we0), 64'(fourth));
         fourth   = 1'b0;
         v        = ($urandom_range(99) < pct);
         in_valid = v;
         in_data  = v ? stream[p] : 8'($urandom);
         if (v && in_ready) begin
            fourth = (p >= 2) && (p < 2 + 4 * nw) && ((p - 2) % 4 == 3);
            p++;
         end
         budget++;
         if (budget > 5000) begin
            check("stream_timeout", 64'(p), 64'(stream.size()));
            break;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("we0_latency", 64'(we0), 64'(fourth));
   endtask

   task automatic finish_image(input string tag, input bit exp_err, input bit exp_pc, input int exp_writes);
      int m;
      repeat (3) @(negedge clk);
      check({tag, "_error"}, 64'(error), 64'(exp_err));
      check({tag, "_resetpc"}, 64'(resetpc), 64'(exp_pc));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_nwrites"}, 64'(log_addr.size()), 64'(exp_writes));
      m = (log_addr.size() < exp_words.size()) ? log_addr.size() : exp_words.size();
      for (int i = 0; i < m; i++) begin
         check({tag, "_addr"}, 64'(log_addr[i]), 64'(4 * i));
         check({tag, "_data"}, 64'(log_data[i]), 64'(exp_words[i]));
      end
   endtask

   task automatic run_image(input string tag, input int n, input int pct,
                            input bit exp_err, input bit exp_pc, input int exp_writes);
      log_addr.delete();
      log_data.delete();
      build_image(n);
      pulse_start();
      send(pct, (n <= MAX_WORDS) ? n : 0);
      finish_image(tag, exp_err, exp_pc, exp_writes);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{6,   100, 1'b0, 1'b1, 6};
      vecs[1] = '{200, 100, 1'b1, 1'b0, 0};
      vecs[2] = '{6,   50,  1'b0, 1'b1, 6};
      vecs[3] = '{1,   100, 1'b0, 1'b1, 1};
      vecs[4] = '{128, 100, 1'b0, 1'b1, 128};
      vecs[5] = '{129, 100, 1'b1, 1'b0, 0};
      vecs[6] = '{256, 60,  1'b1, 1'b0, 0};
      vecs[7] = '{3,   30,  1'b0, 1'b1, 3};

      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      repeat (3) @(negedge clk);
      check("reset_ctrl", 64'({we0, resetpc, busy, error, in_ready}), 64'd0);
      check("reset_addr", 64'(wr_addr0), 64'd0);
      check("reset_data", 64'(wr_din0), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_image($sformatf("vec%0d", i), vecs[i].n, vecs[i].pct,
                   vecs[i].exp_err, vecs[i].exp_pc, vecs[i].exp_writes);
      end

      // empty image: resetpc rises two cycles after the second header byte
      log_addr.delete();
      log_data.delete();
      pulse_start();
      @(negedge clk);
      check("empty_hdr0_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_data  = 8'h00;
      @(negedge clk);
      in_data  = 8'h00;
      @(negedge clk);
      in_valid = 1'b0;
      check("empty_resetpc_t1", 64'(resetpc), 64'd0);
      @(negedge clk);
      check("empty_resetpc_t2", 64'(resetpc), 64'd1);
      check("empty_no_writes", 64'(log_addr.size()), 64'd0);

      // restart from DONE: resetpc drops the cycle after start
      exp_words.delete();
      pulse_start();
      check("restart_resetpc", 64'(resetpc), 64'd0);
      check("restart_busy", 64'(busy), 64'd1);
      build_image(2);
      send(100, 2);
      finish_image("restart", 1'b0, 1'b1, 2);

      // asynchronous reset after two words are written
      log_addr.delete();
      log_data.delete();
      build_image(6);
      stream = stream[0:9];
      pulse_start();
      send(100, 6);
      @(negedge clk);
      check("midload_writes", 64'(log_addr.size()), 64'd2);
      #2 reset = 1'b0;
      #1;
      check("midload_ctrl", 64'({we0, resetpc, busy, error, in_ready}), 64'd0);
      check("midload_addr", 64'(wr_addr0), 64'd0);
      check("midload_data", 64'(wr_din0), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      run_image("after_reset", 1, 100, 1'b0, 1'b1, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
      // single ADDI x0,x0,0 word with a correct then a wrong sum byte
      log_addr.delete();
      log_data.delete();
      exp_words.delete();
      exp_words.push_back(32'h0000_0013);
      stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
      pulse_start();
      send(100, 1);
      finish_image("csum_ok", 1'b0, 1'b1, 1);
      log_addr.delete();
      log_data.delete();
      stream = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h14};
      pulse_start();
      send(100, 1);
      finish_image("csum_bad", 1'b1, 1'b0, 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream of the pipeline top: streams a program image into instruction memory, then releases the PC.
- Consumes a byte stream with a valid/ready handshake, for example from a UART RX or a debug bridge.
- Assembles little-endian 32-bit words and drives the instruction-memory write port (we0/wr_addr0/wr_din0).
- Asserts resetpc only after the whole image is written, which replaces the hand-driven load sequence in benches.

Parameters:
- ADDR_W, 9, width of wr_addr0; byte address.
- MAX_WORDS, 128, instruction-memory depth in words. Must be ≤ 2^ADDR_W/4.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- in_valid  in  1  in_data holds a valid byte.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle. Transfer occurs when in_valid && in_ready.
- we0  out  1  instruction-memory write enable, one-cycle pulse per word.
- wr_addr0  out  ADDR_W  byte address of the write, equal to 4*word_index.
- wr_din0  out  32  word to write.
- resetpc  out  1  0 holds the pipeline PC in reset; 1 lets it run.
- busy  out  1  high in HDR0/HDR1/WORD/WRITE/CSUM.
- error  out  1  high in ERR.

Behaviour:
- Reset (asynchronous, active-low) forces state IDLE and clears all registered outputs: we0=0, wr_addr0=0, wr_din0=0, resetpc=0, busy=0, error=0, in_ready=0. Reset also clears the word index, the byte index and the word count N.
- Stream format: N[7:0], then N[15:8], then N words of 4 bytes each, least-significant byte first.
- State transitions:
  - IDLE: start -> HDR0.
  - HDR0: in_ready=1; on transfer latch N[7:0] -> HDR1.
  - HDR1: in_ready=1; on transfer latch N[15:8]. Then:
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERR.
    - otherwise -> WORD with byte index 0 and word index 0.
  - WORD: in_ready=1. Each transfer shifts its byte into lane [8*b +: 8] and increments b. The 4th transfer (b==3) -> WRITE.
  - WRITE: in_ready=0. we0=1 for exactly this one cycle, with wr_addr0=4*word_index and wr_din0=the assembled word. The word index then increments. If the index now equals N -> CSUM if the feature is compiled in, else DONE; otherwise -> WORD.
  - DONE: resetpc=1, registered, so it rises the cycle after entering DONE. start -> HDR0, and resetpc drops to 0 the following cycle.
  - ERR: error=1 and resetpc=0. start -> HDR0 and clears error.
- start while busy=1 is ignored.
- Latency: we0 asserts exactly 1 cycle after the 4th byte transfer of a word. Throughput is one word per 5 cycles at full in_valid rate.
- Gaps in in_valid stall the FSM with no state change; partial words are retained.
- wr_addr0 is computed at ADDR_W bits; the word index never exceeds MAX_WORDS-1, so wr_addr0 never wraps.
- Outside WRITE, we0=0 and wr_addr0/wr_din0 hold their last values.
- An asynchronous reset mid-load abandons the image and leaves resetpc=0. Words already written stay in memory.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CSUM with in_ready=1 and accepts one byte.
  - The expected value is the 8-bit modulo-256 sum of all data bytes, header excluded.
  - Match -> DONE; mismatch -> ERR. Words are already written, but resetpc stays 0.
- Undefined: no CSUM state and no checksum register; the last WRITE goes straight to DONE.

Decomposition:
- Package prog_loader_pkg: the state enum (IDLE, HDR0, HDR1, WORD, WRITE, CSUM, DONE, ERR), the header byte count (2), and BYTES_PER_WORD=4.
- One sub-module, prog_loader_packer: the byte-to-word shift register with byte counter. Its ports are clk, reset, shift_en, byte_in, clr, word_out and full.

Test Plan:
- Full load: N=6 with 24 bytes and in_valid held high -> six we0 pulses at wr_addr0 = 0, 4, 8, 12, 16, 20; wr_din0 equals each little-endian word; resetpc=1 one cycle after DONE; the pipeline then executes the program.
- Empty image: bytes 00 00 -> no we0 pulse; resetpc=1 two cycles after the second header byte.
- Oversize image: N=200 (C8 00) -> error=1 and no writes. start then a valid image -> error clears and the load completes.
- Backpressure: in_valid toggles randomly at 50% -> identical addresses and data to the full-load case; in_ready=0 during every WRITE cycle.
- Reset mid-load: reset low after word 2 is written -> all outputs return to reset values at once. A new load of N=1 then writes address 0 correctly.
- With PROG_LOADER_CHECKSUM_EN, word 0x00000013 (ADDI x0, x0, 0):
  - checksum byte 0x13 -> DONE and resetpc=1;
  - checksum byte 0x14 -> ERR and resetpc=0.
